// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// operation encoding, slice width and the sequencer state type.
package alu_pkg;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;
    localparam int   NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer.
// Feeds an external 4-bit carry-lookahead adder one slice per cycle,
// LSB slice first, carrying Cout forward between slices. Subtraction is
// A + ~B + 1: B is inverted at acceptance and the first carry-in is 1.
// The finished result and NZCV-style flags are held until retired.
module nibble_serial_add_ctrl
    import alu_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                rst_n,
    // operand handshake
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    in_a_i,
    input  logic [WIDTH-1:0]    in_b_i,
    input  logic                in_op_i,
    // external 4-bit adder
    output logic [NIBBLE_W-1:0] add_a_o,
    output logic [NIBBLE_W-1:0] add_b_o,
    output logic                add_cin_o,
    input  logic [NIBBLE_W-1:0] add_s_i,
    input  logic                add_cout_i,
    input  logic                add_ovf_i,
    // result handshake
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [WIDTH-1:0]    out_sum_o,
    output logic                out_c_o,
    output logic                out_v_o,
    output logic                out_z_o,
    output logic                out_n_o
);

    // idx must be at least one bit wide even for tiny slice counts
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // partial sum built up slice by slice while running
    logic [WIDTH-1:0]   part_q, part_d;
    // retired-result registers, only rewritten when a new result completes
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_q, c_d;
    logic               v_q, v_d;
    logic               z_q, z_d;
    logic               n_q, n_d;

    // slice views of the operands and the partial sum with the current
    // adder output merged into the active slice
    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [WIDTH-1:0]    full_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
            assign a_nib[gi] = a_q[NIBBLE_W*gi +: NIBBLE_W];
            assign b_nib[gi] = b_q[NIBBLE_W*gi +: NIBBLE_W];
            assign full_sum[NIBBLE_W*gi +: NIBBLE_W] =
                (idx_q == IDX_W'(gi)) ? add_s_i : part_q[NIBBLE_W*gi +: NIBBLE_W];
        end
    endgenerate

    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    // next-state, datapath updates and handshake/adder outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        part_d      = part_q;
        sum_d       = sum_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        add_a_o     = '0;
        add_b_o     = '0;
        add_cin_o   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = (in_op_i == OP_SUB) ? ~in_b_i : in_b_i;
                    // the "+1" of two's-complement subtraction enters as Cin
                    carry_d = in_op_i;
                    idx_d   = '0;
                    part_d  = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                add_a_o   = a_nib[idx_q];
                add_b_o   = b_nib[idx_q];
                add_cin_o = carry_q;
                part_d    = full_sum;
                carry_d   = add_cout_i;
                if (idx_q == IDX_LAST) begin
                    // top slice: its Cout and overflow are the word flags
                    idx_d   = '0;
                    sum_d   = full_sum;
                    c_d     = add_cout_i;
                    v_d     = add_ovf_i;
                    z_d     = (full_sum == '0);
                    n_d     = full_sum[WIDTH-1];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                out_valid_o = 1'b1;
                // no bypass: a new operand is only taken once back in IDLE
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_sum_o = sum_q;
    assign out_c_o   = c_q;
    assign out_v_o   = v_q;
    assign out_z_o   = z_q;
    assign out_n_o   = n_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: models the external 4-bit adder,
// issues directed and random operations, and checks results through a
// scoreboard queue drained by an independent output monitor.
module tb_nibble_serial_add_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_op = 1'b0;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout, add_ovf;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_c, out_v, out_z, out_n;

    int   total = 0;
    int   bad = 0;
    int   txn = 0;
    bit   rand_rdy_en = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_a_i     (in_a),
        .in_b_i     (in_b),
        .in_op_i    (in_op),
        .add_a_o    (add_a),
        .add_b_o    (add_b),
        .add_cin_o  (add_cin),
        .add_s_i    (add_s),
        .add_cout_i (add_cout),
        .add_ovf_i  (add_ovf),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum),
        .out_c_o    (out_c),
        .out_v_o    (out_v),
        .out_z_o    (out_z),
        .out_n_o    (out_n)
    );

    // behavioural stand-in for the external 4-bit overflow adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign add_ovf = (add_a[3] == add_b[3]) && (add_s[3] != add_a[3]);

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endfunction

    // word-level reference: plain integer arithmetic on the whole operands
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic op);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r;
        if (op) begin
            e.sum = W'(ua - ub);
            e.c   = (ua >= ub);
            r     = sa - sb;
        end else begin
            e.sum = W'(ua + ub);
            e.c   = (ua + ub) > ((1 << W) - 1);
            r     = sa + sb;
        end
        e.v = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        e.z = (e.sum == '0);
        e.n = e.sum[W-1];
        return e;
    endfunction

    // monitor: every retired result is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'(out_sum), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d sum=%h c=%b v=%b z=%b n=%b", txn, out_sum, out_c, out_v, out_z, out_n);
                chk("sum", 32'(out_sum), 32'(e.sum));
                chk("flag_c", 32'(out_c), 32'(e.c));
                chk("flag_v", 32'(out_v), 32'(e.v));
                chk("flag_z", 32'(out_z), 32'(e.z));
                chk("flag_n", 32'(out_n), 32'(e.n));
            end
        end
    end

    // random consumer stall during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // directed op with out_ready already set; checks the adder drive per slice,
    // latency, and (when out_ready=1) the return to IDLE
    task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic op, exp_t e);
        logic [W-1:0] bp;
        int mask;
        int cin_exp;
        bp = op ? ~b : b;
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        sb_q.push_back(e);
        step();
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_op = $urandom_range(0, 1);
        for (int k = 0; k < NIB; k++) begin
            mask = (1 << (4*k)) - 1;
            cin_exp = ((int'(a) & mask) + (int'(bp) & mask) + int'(op)) >> (4*k);
            chk("run_add_a", 32'(add_a), (int'(a) >> (4*k)) & 15);
            chk("run_add_b", 32'(add_b), (int'(bp) >> (4*k)) & 15);
            chk("run_add_cin", 32'(add_cin), 32'(cin_exp));
            chk("run_out_valid", 32'(out_valid), 32'd0);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_add_cin", 32'(add_cin), 32'd0);
        if (out_ready) begin
            step();
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    // random-phase issue: holds in_valid until accepted, bounded wait
    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic op);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (in_ready) begin
                sb_q.push_back(model(a, b, op));
                ok = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return W'(1 << (W-1));
            3: return W'((1 << (W-1)) - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        exp_t e;
        // reset state
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_flags", 32'({out_c, out_v, out_z, out_n}), 32'd0);
        chk("rst_adder_drive", 32'({add_a, add_b, add_cin}), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;

        // directed vectors with hand-derived results
        e = '{sum: 16'h5555, c: 0, v: 0, z: 0, n: 0}; run_op(16'h1234, 16'h4321, 1'b0, e);
        e = '{sum: 16'h8000, c: 0, v: 1, z: 0, n: 1}; run_op(16'h7FFF, 16'h0001, 1'b0, e);
        e = '{sum: 16'h0000, c: 1, v: 0, z: 1, n: 0}; run_op(16'hFFFF, 16'h0001, 1'b0, e);
        e = '{sum: 16'hFFFE, c: 0, v: 0, z: 0, n: 1}; run_op(16'h0005, 16'h0007, 1'b1, e);
        e = '{sum: 16'h7FFF, c: 1, v: 1, z: 0, n: 0}; run_op(16'h8000, 16'h0001, 1'b1, e);

        // backpressure: result held 3 cycles, a second request is ignored
        out_ready = 1'b0;
        e = '{sum: 16'h3333, c: 0, v: 0, z: 0, n: 0}; run_op(16'h1111, 16'h2222, 1'b0, e);
        in_a = 16'h0F0F; in_b = 16'h0101; in_op = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_sum", 32'(out_sum), 32'h3333);
        end
        out_ready = 1'b1;
        step();
        chk("bp_retire_valid", 32'(out_valid), 32'd0);
        chk("bp_retire_in_ready", 32'(in_ready), 32'd1);
        sb_q.push_back('{sum: 16'h1010, c: 0, v: 0, z: 0, n: 0});
        step();
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        for (int t = 0; t < 20 && sb_q.size() != 0; t++) step();
        chk("bp_drain", 32'(sb_q.size()), 32'd0);
        step();

        // reset in the middle of RUN, with a carry in flight
        in_a = 16'hFFFF; in_b = 16'h0001; in_op = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_adder_drive", 32'({add_a, add_b, add_cin}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        e = '{sum: 16'h0002, c: 0, v: 0, z: 0, n: 0}; run_op(16'h0001, 16'h0001, 1'b0, e);

        // random back-to-back traffic with a stalling consumer
        rand_rdy_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            issue(rand_operand(), rand_operand(), logic'($urandom_range(0, 1)));
        end
        rand_rdy_en = 1'b0;
        step();
        out_ready = 1'b1;
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) step();
        chk("final_drain", 32'(sb_q.size()), 32'd0);
        chk("final_txn_count", 32'(txn), 32'd1008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing the team's existing 4-bit carry-lookahead adder with overflow output, one nibble per cycle, LSB nibble first. It sits directly upstream of that adder and drives its A/B/Cin. It also sits downstream of it, consuming S/Cout/overflow and registering the carry between nibbles. Operands enter on a valid/ready handshake; the result and flags leave on a valid/ready handshake.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width WIDTH = 4*NIBBLES (legal 2..8)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  high only in IDLE
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  1  0 = ADD, 1 = SUB (A - B)
add_a  output  4  to adder A
add_b  output  4  to adder B (inverted for SUB)
add_cin  output  1  to adder Cin
add_s  input  4  adder sum
add_cout  input  1  adder carry out
add_ovf  input  1  adder signed overflow (C3 xor Cout)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result
out_c  output  1  carry out; for SUB, 1 = no borrow
out_v  output  1  signed overflow
out_z  output  1  out_sum == 0
out_n  output  1  out_sum[WIDTH-1]

Behaviour:
- Reset (async, rst_n low): state IDLE, idx 0, carry_reg 0, operand/result regs 0. Outputs: in_ready 1, out_valid 0, out_sum/out_c/out_v/out_z/out_n 0, add_a/add_b/add_cin 0. Takes effect immediately, including mid-RUN or in DONE; any in-flight operation is discarded with no output.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid & in_ready edge: latch a_reg=in_a; latch b_reg=in_b, or ~in_b if in_op=1; carry_reg=in_op (Cin 1 for SUB); idx=0; go RUN.
- RUN: in_ready=0. add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry_reg (combinational from regs).
  - Each edge: sum_reg[4*idx+:4]<=add_s; carry_reg<=add_cout; idx<=idx+1.
  - On the edge where idx==NIBBLES-1: out_c<=add_cout, out_v<=add_ovf, out_sum<=full sum including the last nibble, out_z/out_n computed from that sum; idx<=0; go DONE.
  - Outside RUN, add_a/add_b/add_cin are 0.
- DONE: out_valid=1; outputs held stable until out_ready. On out_ready edge: go IDLE; out_valid drops next cycle.
  - Result fields keep their values until the next DONE; only out_valid qualifies them.
  - No bypass: a new operand cannot be accepted on the same edge as result retirement; in_ready rises the cycle after.
- Latency: out_valid asserts exactly NIBBLES edges after the accepting edge. Max throughput is one op per NIBBLES+2 cycles.
- in_valid while in_ready=0 is ignored; upstream must hold it. in_a/in_b/in_op changes after acceptance have no effect.
- Widths: all arithmetic is modulo 2^WIDTH. Overflow is taken solely from the top nibble's add_ovf. No combinational path from in_* to out_*.
- idx is a counter of width $clog2(NIBBLES). It never exceeds NIBBLES-1 and returns to 0 on leaving RUN.

Decomposition:
- Shared package alu_pkg holds: OP_ADD=1'b0, OP_SUB=1'b1, NIBBLE_W=4, and the state enum (IDLE, RUN, DONE).
- No internal sub-module; the adder stays external.
- Verification wrapper nibble_serial_add_top instantiates this block plus the existing 4-bit overflow adder, port-to-port.

Test Plan:
- ADD 0x1234 + 0x4321 -> out_sum 0x5555, c0 v0 z0 n0; out_valid exactly 4 edges after accept; add_cin sequence 0,0,0,0.
- ADD 0x7FFF + 0x0001 -> 0x8000, c0 v1 z0 n1; ADD 0xFFFF + 0x0001 -> 0x0000, c1 v0 z1 n0; carry ripples through all 4 nibble cycles.
- SUB 0x0005 - 0x0007 -> 0xFFFE, c0 v0 z0 n1; SUB 0x8000 - 0x0001 -> 0x7FFF, c1 v1 z0 n0; first add_cin=1, add_b=~B nibble.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, second in_valid ignored. Then out_ready=1 -> IDLE; second op accepted the following cycle.
- Reset mid-RUN: assert rst_n=0 at idx=2 -> all outputs 0 and in_ready=1 immediately. After release, ADD 0x0001 + 0x0001 -> 0x0002 with no stale carry.
- Back-to-back random ADD/SUB (1000 ops, out_ready randomly stalled) vs. reference model -> sum and all flags match on every out_valid & out_ready.
